// File: rtl/ifetch_prefetch.sv
// Instruction-fetch initiator: drives the synchronous instruction ROM,
// buffers returned words in a small prefetch FIFO and hands a PC-tagged
// valid/ready stream to decode. Jumps flush the FIFO and squash the
// in-flight read.
module ifetch_prefetch #(
  parameter logic [23:0] RESET_PC   = 24'h000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  output logic        IROM_CS,
  output logic [23:0] IROM_ADDR,
  input  logic [31:0] IROM_DOUT,
  input  logic        JMP_VLD,
  input  logic [23:0] JMP_ADDR,
  output logic        INSTR_VLD,
  output logic [31:0] INSTR,
  output logic [23:0] INSTR_PC,
  input  logic        INSTR_RDY
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t        state;
  logic [23:0]   fetch_pc;
  logic          pend;
  logic [23:0]   pend_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] occupancy;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [23:0]   mem_pc    [FIFO_DEPTH];
  logic          issue;
  logic          push;
  logic          pop;

  // Issue/push/pop decisions. Occupancy counts the in-flight read so the
  // FIFO can never overflow; pop credit is deliberately not used for issue.
  always_comb begin
    occupancy = count + CW'(pend);
    issue     = (state == S_RUN) & EN & ~JMP_VLD & (occupancy < CW'(FIFO_DEPTH));
    push      = pend & ~JMP_VLD;
    pop       = (count != '0) & INSTR_RDY;
  end

  assign IROM_CS   = issue;
  assign IROM_ADDR = fetch_pc;
  assign INSTR_VLD = (count != '0);
  assign INSTR     = mem_instr[rd_ptr];
  assign INSTR_PC  = mem_pc[rd_ptr];

  // Fetch control FSM: a jump from any state forces a one-cycle FLUSH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else if (JMP_VLD) begin
      state <= S_FLUSH;
    end else begin
      case (state)
        S_IDLE:  if (EN) state <= S_RUN;
        S_RUN:   if (!EN) state <= S_IDLE;
        S_FLUSH: state <= EN ? S_RUN : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fetch PC and pending-read tracking; a jump retargets and squashes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc <= RESET_PC;
      pend     <= 1'b0;
      pend_pc  <= '0;
    end else begin
      pend <= issue;
      if (JMP_VLD) begin
        fetch_pc <= JMP_ADDR;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 24'd1;
        pend_pc  <= fetch_pc;
      end
    end
  end

  // Prefetch FIFO: write returning ROM words, advance on decode accept,
  // and empty completely on a jump.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (JMP_VLD) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= IROM_DOUT;
        mem_pc[wr_ptr]    <= pend_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: ROM models, a scoreboard of expected
// {PC, word} pairs popped by monitors on every accepted instruction, and
// directed checks on the ROM strobe/address and valid timing.
module tb_ifetch_prefetch;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic        IROM_CS;
  logic [23:0] IROM_ADDR;
  logic [31:0] IROM_DOUT;
  logic        JMP_VLD;
  logic [23:0] JMP_ADDR;
  logic        INSTR_VLD;
  logic [31:0] INSTR;
  logic [23:0] INSTR_PC;
  logic        INSTR_RDY;

  logic        rst2_n;
  logic        en2;
  logic        cs2;
  logic [23:0] addr2;
  logic [31:0] dout2;
  logic        vld2;
  logic [31:0] instr2;
  logic [23:0] pc2;

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  int pops2 = 0;
  bit saw_200 = 1'b0;

  logic [55:0] exp_q [$];
  logic [55:0] exp2_q [$];

  always #5 CLK = ~CLK;

  ifetch_prefetch #(.RESET_PC(24'h000000), .FIFO_DEPTH(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN),
    .IROM_CS(IROM_CS), .IROM_ADDR(IROM_ADDR), .IROM_DOUT(IROM_DOUT),
    .JMP_VLD(JMP_VLD), .JMP_ADDR(JMP_ADDR),
    .INSTR_VLD(INSTR_VLD), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .INSTR_RDY(INSTR_RDY)
  );

  ifetch_prefetch #(.RESET_PC(24'hFFFFFE), .FIFO_DEPTH(4)) u_dut2 (
    .CLK(CLK), .RST_N(rst2_n), .EN(en2),
    .IROM_CS(cs2), .IROM_ADDR(addr2), .IROM_DOUT(dout2),
    .JMP_VLD(1'b0), .JMP_ADDR(24'h000000),
    .INSTR_VLD(vld2), .INSTR(instr2), .INSTR_PC(pc2),
    .INSTR_RDY(1'b1)
  );

  function automatic logic [31:0] rom_val(input logic [23:0] a);
    return 32'hA000_0000 + {8'h00, a};
  endfunction

  // Synchronous ROMs, one-cycle read latency.
  always @(posedge CLK) begin
    if (IROM_CS) IROM_DOUT <= rom_val(IROM_ADDR);
    if (cs2)     dout2     <= rom_val(addr2);
  end

  // Monitors: every accepted instruction must match the scoreboard head.
  always @(negedge CLK) begin
    logic [55:0] e;
    if (RST_N && INSTR_VLD && INSTR_RDY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got pc=%h instr=%h, required no output", INSTR_PC, INSTR);
      end else begin
        e = exp_q.pop_front();
        if ({INSTR_PC, INSTR} !== e) begin
          errors++;
          $display("FAIL stream: got pc=%h instr=%h, required pc=%h instr=%h",
                   INSTR_PC, INSTR, e[55:32], e[31:0]);
        end
      end
    end
    if (IROM_CS) issue_cnt++;
    if (IROM_CS && IROM_ADDR == 24'h000200) saw_200 = 1'b1;
  end

  always @(negedge CLK) begin
    logic [55:0] e;
    if (rst2_n && vld2) begin
      checks++;
      pops2++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_extra: got pc=%h, required no output", pc2);
      end else begin
        e = exp2_q.pop_front();
        if ({pc2, instr2} !== e) begin
          errors++;
          $display("FAIL wrap_stream: got pc=%h instr=%h, required pc=%h instr=%h",
                   pc2, instr2, e[55:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic probe();
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_seq(input logic [23:0] start, input int unsigned n);
    logic [23:0] pc;
    pc = start;
    for (int unsigned i = 0; i < n; i++) begin
      exp_q.push_back({pc, rom_val(pc)});
      pc = pc + 24'd1;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; INSTR_RDY = 1'b0; JMP_VLD = 1'b0; JMP_ADDR = '0;
    rst2_n = 1'b0; en2 = 1'b0;
    run(3);
    probe();
    chk("rst_vld", {31'd0, INSTR_VLD}, 32'd0);
    chk("rst_cs", {31'd0, IROM_CS}, 32'd0);
    chk("rst_instr", INSTR, 32'd0);
    chk("rst_pc", {8'd0, INSTR_PC}, 32'd0);

    // Fill with decode stalled: exactly FIFO_DEPTH issues, then hold.
    step(); RST_N = 1'b1; EN = 1'b1; issue_cnt = 0; push_seq(24'h0, 64);
    probe(); chk("idle_cs", {31'd0, IROM_CS}, 32'd0);
    step(); probe();
    chk("first_cs", {31'd0, IROM_CS}, 32'd1);
    chk("first_addr", {8'd0, IROM_ADDR}, 32'd0);
    step(); probe(); chk("vld_lat_early", {31'd0, INSTR_VLD}, 32'd0);
    step(); probe();
    chk("vld_lat", {31'd0, INSTR_VLD}, 32'd1);
    chk("head_pc", {8'd0, INSTR_PC}, 32'd0);
    chk("head_instr", INSTR, 32'hA000_0000);
    run(7); probe();
    chk("full_issues", issue_cnt, 32'd4);
    chk("full_cs", {31'd0, IROM_CS}, 32'd0);

    // Drain and stream; continuity is checked by the scoreboard.
    step(); INSTR_RDY = 1'b1;
    run(20);

    // Fetch disable: no new issue, pending word still lands and drains.
    EN = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      probe(); chk("en_off_cs", {31'd0, IROM_CS}, 32'd0);
      step();
    end
    probe(); chk("en_off_drained", {31'd0, INSTR_VLD}, 32'd0);
    step(); EN = 1'b1;
    run(6);

    // Jump with three buffered words and a read in flight.
    INSTR_RDY = 1'b0;
    run(2);
    JMP_VLD = 1'b1; JMP_ADDR = 24'h000100;
    probe(); chk("pre_jmp_vld", {31'd0, INSTR_VLD}, 32'd1);
    step(); JMP_VLD = 1'b0; INSTR_RDY = 1'b1;
    exp_q.delete(); push_seq(24'h000100, 64);
    probe();
    chk("jmp_flush_vld", {31'd0, INSTR_VLD}, 32'd0);
    chk("jmp_flush_cs", {31'd0, IROM_CS}, 32'd0);
    step(); probe();
    chk("jmp_cs", {31'd0, IROM_CS}, 32'd1);
    chk("jmp_addr", {8'd0, IROM_ADDR}, 32'h000100);
    step(); probe(); chk("jmp_vld_early", {31'd0, INSTR_VLD}, 32'd0);
    step(); probe();
    chk("jmp_vld", {31'd0, INSTR_VLD}, 32'd1);
    chk("jmp_pc", {8'd0, INSTR_PC}, 32'h000100);
    run(8);

    // Back-to-back jumps: the later target wins, nothing from 0x200 appears.
    saw_200 = 1'b0;
    JMP_VLD = 1'b1; JMP_ADDR = 24'h000200;
    step(); JMP_ADDR = 24'h000300; exp_q.delete();
    probe(); chk("jj_cs1", {31'd0, IROM_CS}, 32'd0);
    step(); JMP_VLD = 1'b0; push_seq(24'h000300, 64);
    probe(); chk("jj_cs2", {31'd0, IROM_CS}, 32'd0);
    step(); probe();
    chk("jj_cs", {31'd0, IROM_CS}, 32'd1);
    chk("jj_addr", {8'd0, IROM_ADDR}, 32'h000300);
    step(); step(); probe();
    chk("jj_vld", {31'd0, INSTR_VLD}, 32'd1);
    chk("jj_pc", {8'd0, INSTR_PC}, 32'h000300);
    run(8);
    probe(); chk("jj_no_200", {31'd0, saw_200}, 32'd0);

    // Asynchronous reset with two buffered words and a read pending.
    step(); RST_N = 1'b0; exp_q.delete();
    step(); RST_N = 1'b1; EN = 1'b1; INSTR_RDY = 1'b0;
    run(4);
    #1 RST_N = 1'b0;
    #1;
    chk("arst_vld", {31'd0, INSTR_VLD}, 32'd0);
    chk("arst_cs", {31'd0, IROM_CS}, 32'd0);
    run(2); probe();
    chk("arst_hold_vld", {31'd0, INSTR_VLD}, 32'd0);
    step(); RST_N = 1'b1; INSTR_RDY = 1'b1; push_seq(24'h0, 64);
    step(); probe();
    chk("arst_restart_cs", {31'd0, IROM_CS}, 32'd1);
    chk("arst_restart_addr", {8'd0, IROM_ADDR}, 32'd0);
    run(10);

    // Address wrap from a non-zero reset PC on the second instance.
    exp2_q.push_back({24'hFFFFFE, rom_val(24'hFFFFFE)});
    exp2_q.push_back({24'hFFFFFF, rom_val(24'hFFFFFF)});
    for (int unsigned i = 0; i < 12; i++) exp2_q.push_back({24'(i), rom_val(24'(i))});
    step(); rst2_n = 1'b1; en2 = 1'b1; pops2 = 0;
    step(); probe();
    chk("wrap_cs", {31'd0, cs2}, 32'd1);
    chk("wrap_addr", {8'd0, addr2}, 32'h00FFFFFE);
    run(8); probe();
    chk("wrap_count", {31'd0, (pops2 >= 4)}, 32'd1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction-fetch initiator for the Tawas core. Drives the synchronous instruction ROM port (word address, chip select, 1-cycle read latency) and buffers returned words in a small prefetch FIFO.
- Presents a valid/ready instruction stream, tagged with its PC, to the decode stage.
- Handles jump redirects by flushing the FIFO and squashing any in-flight read.

Parameters:
- RESET_PC, 24'h000000, word address fetched first after reset/enable.
- FIFO_DEPTH, 4, prefetch entries (power of 2, 2..16).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  fetch enable; 0 holds fetch, buffered words remain available.
- IROM_CS  output  1  ROM read strobe, sampled by ROM on CLK rise.
- IROM_ADDR  output  24  ROM word address, valid when IROM_CS=1.
- IROM_DOUT  input  32  ROM read data, valid the cycle after IROM_CS=1.
- JMP_VLD  input  1  redirect request, 1-cycle pulse.
- JMP_ADDR  input  24  redirect target word address.
- INSTR_VLD  output  1  head FIFO entry valid.
- INSTR  output  32  head instruction word.
- INSTR_PC  output  24  word address of INSTR.
- INSTR_RDY  input  1  decode accepts head entry when INSTR_VLD&INSTR_RDY.

Behaviour:
- Reset (RST_N=0, async):
  - state=IDLE, fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0, pend=0.
  - IROM_CS=0, INSTR_VLD=0, INSTR/INSTR_PC=0.
- States:
  - IDLE: no fetch. Goes to RUN when EN=1.
  - RUN: fetch per issue rule. Goes to IDLE when EN=0; go back to RUN on EN=1 resumes at fetch_pc.
  - FLUSH: one-cycle state entered on JMP_VLD from any state. IROM_CS=0. Returns to RUN if EN=1, else IDLE.
- Issue rule: IROM_CS = (state==RUN) & EN & ~JMP_VLD & (count + pend < FIFO_DEPTH).
  - IROM_CS is combinational from registered state plus EN/JMP_VLD.
  - IROM_ADDR = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+1 (24-bit wrap, 24'hFFFFFF -> 0), pend <= 1, pend_pc <= fetch_pc. Otherwise pend <= 0.
  - Pop credit is never used for issue (conservative): no overflow possible.
- Return: in a cycle with pend=1 and no JMP_VLD, {IROM_DOUT, pend_pc} is written at wr_ptr at the clock edge.
- Output: INSTR_VLD = (count != 0). INSTR/INSTR_PC come from rd_ptr (registered FIFO storage).
  - Pop when INSTR_VLD & INSTR_RDY.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Jump (JMP_VLD=1 in cycle N):
  - At edge N: count<=0, rd_ptr<=wr_ptr<=0, pend<=0 (any in-flight word is discarded), fetch_pc<=JMP_ADDR, state<=FLUSH.
  - A pop in cycle N still completes (decode is responsible for squashing it).
  - Cycle N+1: FLUSH, IROM_CS=0.
  - Cycle N+2: IROM_CS=1, IROM_ADDR=JMP_ADDR.
  - Cycle N+3: ROM data written.
  - Cycle N+4: INSTR_VLD=1, INSTR_PC=JMP_ADDR.
  - JMP_VLD during FLUSH restarts FLUSH with the new target; the latest target wins.
- Steady state: with INSTR_RDY=1 continuously, sustains 1 instruction/cycle after fill (first issue at RUN entry, first INSTR_VLD 2 cycles later).
- Full:
  - count+pend==FIFO_DEPTH -> IROM_CS=0 and fetch_pc holds.
  - count never exceeds FIFO_DEPTH; no word is dropped or duplicated.
- EN deassert mid-stream: no new issue; an already-pending read still completes into the FIFO.
- Reset mid-operation clears all state immediately; a ROM word returned after reset is ignored (pend=0).

Test Plan:
- Reset release, EN=1, INSTR_RDY=1, ROM[i]=32'hA000_0000+i -> IROM_CS rises first RUN cycle with ADDR=0. INSTR_VLD two cycles later, then INSTR=A0000000, A0000001, ... one per cycle, INSTR_PC=0,1,2,...
- INSTR_RDY=0 for 10 cycles -> exactly 4 issues, IROM_CS then held 0, count=4. INSTR_RDY=1 -> PCs 0..3 drained in order, fetching resumes at PC 4 with no gap/duplicate.
- JMP_VLD with JMP_ADDR=24'h000100 while FIFO holds 3 words and a read is pending:
  - FIFO empties next cycle.
  - Stale pending word is not written.
  - IROM_ADDR=0x100 two cycles after jump.
  - INSTR_PC=0x100 four cycles after jump.
- Back-to-back JMP_VLD (0x200 then 0x300 next cycle) -> only 0x300 is fetched; no 0x200 word ever reaches INSTR.
- RESET_PC=24'hFFFFFE, continuous run -> INSTR_PC sequence FFFFFE, FFFFFF, 000000, 000001.
- RST_N asserted while pend=1 and count=2 -> INSTR_VLD=0 and IROM_CS=0 immediately (async). After release, fetch restarts at RESET_PC.
